// File: rtl/mac_accumulator.sv
// Four-lane unsigned MAC accumulator with per-lane sticky carry flags.
// Counts len products per accumulation, then pulses out_valid for one cycle.
`ifndef MAC_ACC_WIDTH
`define MAC_ACC_WIDTH 32
`endif
`ifndef MAC_SINGLE
`define MAC_SINGLE 2'b00
`endif
`ifndef MAC_DUAL
`define MAC_DUAL 2'b01
`endif
`ifndef MAC_QUAD
`define MAC_QUAD 2'b10
`endif

module mac_accumulator #(
  parameter int ACC_WIDTH = `MAC_ACC_WIDTH,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  input  logic [1:0]           cfg,
  input  logic [LEN_WIDTH-1:0] acc_len,
  input  logic                 in_valid,
  input  logic [ACC_WIDTH-1:0] product0,
  input  logic [ACC_WIDTH-1:0] product1,
  input  logic [ACC_WIDTH-1:0] product2,
  input  logic [ACC_WIDTH-1:0] product3,
  output logic [ACC_WIDTH-1:0] partial0,
  output logic [ACC_WIDTH-1:0] partial1,
  output logic [ACC_WIDTH-1:0] partial2,
  output logic [ACC_WIDTH-1:0] partial3,
  output logic [1:0]           cfg_out,
  output logic                 out_valid,
  output logic                 busy,
  output logic [3:0]           overflow
);

  typedef enum logic {IDLE, ACC} state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] count_inc;
  logic [1:0]           cfg_q, cfg_d;
  logic [3:0]           ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] part_q [4];
  logic [ACC_WIDTH-1:0] part_d [4];
  logic [ACC_WIDTH-1:0] prod [4];
  logic [ACC_WIDTH:0]   sum [4];

  assign prod[0] = product0;
  assign prod[1] = product1;
  assign prod[2] = product2;
  assign prod[3] = product3;

  // Lanes stay independent; bit ACC_WIDTH is the lane carry-out.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign sum[g] = {1'b0, part_q[g]} + {1'b0, prod[g]};
  end

  assign count_inc = count_q + LEN_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    len_d       = len_q;
    cfg_d       = cfg_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    part_d      = part_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cfg_d   = cfg;
          len_d   = (acc_len == '0) ? LEN_WIDTH'(1) : acc_len;
          count_d = '0;
          ovf_d   = '0;
          for (int i = 0; i < 4; i++) part_d[i] = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        if (in_valid) begin
          for (int i = 0; i < 4; i++) begin
            part_d[i] = sum[i][ACC_WIDTH-1:0];
            ovf_d[i]  = ovf_q[i] | sum[i][ACC_WIDTH];
          end
          count_d = count_inc;
          if (count_inc == len_q) begin
            state_d     = IDLE;
            out_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      len_q       <= LEN_WIDTH'(1);
      cfg_q       <= `MAC_SINGLE;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) part_q[i] <= '0;
    end else if (en) begin
      state_q     <= state_d;
      count_q     <= count_d;
      len_q       <= len_d;
      cfg_q       <= cfg_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < 4; i++) part_q[i] <= part_d[i];
    end
  end

  assign partial0  = part_q[0];
  assign partial1  = part_q[1];
  assign partial2  = part_q[2];
  assign partial3  = part_q[3];
  assign cfg_out   = cfg_q;
  assign overflow  = ovf_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == ACC);

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: directed scenarios plus
// randomized traffic against a lane-total reference model.
module tb_mac_accumulator;

  localparam int W = 32;
  localparam logic [1:0] SINGLE = 2'b00;
  localparam logic [1:0] DUAL   = 2'b01;
  localparam logic [1:0] QUAD   = 2'b10;
  localparam int VW = 4*W + 8;

  logic         clk = 1'b0;
  logic         rst, en, start, in_valid;
  logic [1:0]   cfg;
  logic [7:0]   acc_len;
  logic [W-1:0] product0, product1, product2, product3;
  logic [W-1:0] partial0, partial1, partial2, partial3;
  logic [1:0]   cfg_out;
  logic         out_valid, busy;
  logic [3:0]   overflow;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Reference model: true (unwrapped) lane totals and transaction progress.
  logic [63:0] e_tot [4];
  logic [1:0]  e_cfg;
  int          e_len, e_cnt;
  logic        e_busy, e_ov;

  always #5 clk = ~clk;

  mac_accumulator #(.ACC_WIDTH(W), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .cfg(cfg),
    .acc_len(acc_len), .in_valid(in_valid),
    .product0(product0), .product1(product1),
    .product2(product2), .product3(product3),
    .partial0(partial0), .partial1(partial1),
    .partial2(partial2), .partial3(partial3),
    .cfg_out(cfg_out), .out_valid(out_valid),
    .busy(busy), .overflow(overflow)
  );

  task automatic model_step();
    logic [W-1:0] p [4];
    p = '{product0, product1, product2, product3};
    if (rst) begin
      for (int i = 0; i < 4; i++) e_tot[i] = 0;
      e_cfg = SINGLE; e_len = 1; e_cnt = 0;
      e_busy = 0; e_ov = 0;
    end else if (en) begin
      e_ov = 0;
      if (!e_busy) begin
        if (start) begin
          for (int i = 0; i < 4; i++) e_tot[i] = 0;
          e_cfg = cfg;
          e_len = (acc_len == 0) ? 1 : int'(acc_len);
          e_cnt = 0; e_busy = 1;
        end
      end else if (in_valid) begin
        for (int i = 0; i < 4; i++) e_tot[i] += 64'(p[i]);
        e_cnt++;
        if (e_cnt == e_len) begin
          e_busy = 0; e_ov = 1;
        end
      end
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [3:0] ov;
    for (int i = 0; i < 4; i++) ov[i] = (e_tot[i][63:W] != 0);
    return {e_tot[0][W-1:0], e_tot[1][W-1:0], e_tot[2][W-1:0],
            e_tot[3][W-1:0], ov, e_cfg, e_busy, e_ov};
  endfunction

  function automatic logic [VW-1:0] act_vec();
    return {partial0, partial1, partial2, partial3,
            overflow, cfg_out, busy, out_valid};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rst = 0; en = 1; start = 0; in_valid = 0;
    product0 = 0; product1 = 0; product2 = 0; product3 = 0;
  endtask

  task automatic test_reset();
    rst = 1; en = 0; start = 1; in_valid = 1;
    cfg = QUAD; acc_len = 5; product0 = 7;
    tick();
    total_cnt++;
    if (act_vec() !== '0)
      $display("FAIL reset_state got %h exp 0", act_vec());
    else pass_cnt++;
    idle_in();
    tick();
    total_cnt++;
    if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL reset_idle got busy=%b ov=%b exp 0 0", busy, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    idle_in();
    start = 1; cfg = QUAD; acc_len = 3;
    tick();
    start = 0; cfg = DUAL; acc_len = 9;
    for (int k = 1; k <= 3; k++) begin
      total_cnt++;
      if (out_valid !== 1'b0 || busy !== 1'b1)
        $display("FAIL basic_pre%0d got ov=%b busy=%b exp 0 1", k, out_valid, busy);
      else pass_cnt++;
      in_valid = 1; product0 = W'(k);
      product2 = $urandom;
      tick();
    end
    idle_in();
    total_cnt++;
    if (out_valid !== 1'b1 || partial0 !== 32'd6 || cfg_out !== QUAD || busy !== 1'b0)
      $display("FAIL basic_done got ov=%b p0=%0d cfg=%b busy=%b exp 1 6 10 0",
               out_valid, partial0, cfg_out, busy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0 || partial0 !== 32'd6 || cfg_out !== QUAD)
      $display("FAIL basic_hold got ov=%b p0=%0d cfg=%b exp 0 6 10", out_valid, partial0, cfg_out);
    else pass_cnt++;
  endtask

  task automatic test_gaps_stall();
    idle_in();
    start = 1; cfg = DUAL; acc_len = 2;
    tick();
    start = 0; in_valid = 1; product0 = 5;
    tick();
    in_valid = 0;
    tick();
    en = 0; in_valid = 1; product0 = 100;
    for (int k = 0; k < 3; k++) tick();
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || partial0 !== 32'd5)
      $display("FAIL stall_hold got ov=%b busy=%b p0=%0d exp 0 1 5", out_valid, busy, partial0);
    else pass_cnt++;
    en = 1; product0 = 7;
    tick();
    idle_in();
    total_cnt++;
    if (out_valid !== 1'b1 || partial0 !== 32'd12)
      $display("FAIL gaps_done got ov=%b p0=%0d exp 1 12", out_valid, partial0);
    else pass_cnt++;
    en = 0;
    tick();
    total_cnt++;
    if (out_valid !== 1'b1)
      $display("FAIL stall_ov_hold got %b exp 1", out_valid);
    else pass_cnt++;
    en = 1;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0)
      $display("FAIL gaps_pulse got %b exp 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    idle_in();
    start = 1; cfg = SINGLE; acc_len = 2;
    tick();
    start = 0; in_valid = 1; product1 = '1;
    tick();
    tick();
    idle_in();
    total_cnt++;
    if (partial1 !== {{(W-1){1'b1}}, 1'b0} || overflow !== 4'b0010 ||
        partial0 !== '0 || partial2 !== '0 || partial3 !== '0 || out_valid !== 1'b1)
      $display("FAIL wrap got p1=%h ovf=%b p0=%h p2=%h p3=%h exp fffffffe 0010 0 0 0",
               partial1, overflow, partial0, partial2, partial3);
    else pass_cnt++;
  endtask

  task automatic test_boundary();
    idle_in();
    start = 1; acc_len = 0; cfg = DUAL; in_valid = 1; product0 = 9;
    tick();
    total_cnt++;
    if (busy !== 1'b1 || partial0 !== '0)
      $display("FAIL start_excl got busy=%b p0=%0d exp 1 0", busy, partial0);
    else pass_cnt++;
    start = 0; product0 = 4;
    tick();
    idle_in();
    total_cnt++;
    if (out_valid !== 1'b1 || partial0 !== 32'd4)
      $display("FAIL len0 got ov=%b p0=%0d exp 1 4", out_valid, partial0);
    else pass_cnt++;
    tick();
    start = 1; acc_len = 3;
    tick();
    acc_len = 1; in_valid = 1;
    for (int k = 1; k <= 3; k++) begin
      product0 = W'(k);
      tick();
      total_cnt++;
      if (out_valid !== (k == 3) || busy !== (k != 3))
        $display("FAIL no_restart%0d got ov=%b busy=%b exp %b %b",
                 k, out_valid, busy, k == 3, k != 3);
      else pass_cnt++;
    end
    idle_in();
    total_cnt++;
    if (partial0 !== 32'd6)
      $display("FAIL no_restart_sum got %0d exp 6", partial0);
    else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    idle_in();
    start = 1; cfg = QUAD; acc_len = 4;
    tick();
    start = 0; in_valid = 1; product0 = 3; product3 = 8;
    tick();
    rst = 1; start = 1;
    tick();
    total_cnt++;
    if (act_vec() !== '0)
      $display("FAIL midop_reset got %h exp 0", act_vec());
    else pass_cnt++;
    idle_in();
    for (int k = 0; k < 4; k++) begin
      tick();
      total_cnt++;
      if (out_valid !== 1'b0)
        $display("FAIL midop_no_ov%0d got %b exp 0", k, out_valid);
      else pass_cnt++;
    end
    start = 1; acc_len = 1;
    tick();
    start = 0; in_valid = 1; product0 = 11;
    tick();
    idle_in();
    total_cnt++;
    if (out_valid !== 1'b1 || partial0 !== 32'd11 || partial3 !== '0)
      $display("FAIL midop_restart got ov=%b p0=%0d p3=%0d exp 1 11 0",
               out_valid, partial0, partial3);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [W-1:0] big;
    idle_in();
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 99) < 2);
      en       = ($urandom_range(0, 9) != 0);
      start    = ($urandom_range(0, 3) != 0);
      in_valid = ($urandom_range(0, 9) < 7);
      cfg      = 2'($urandom_range(0, 2));
      acc_len  = 8'($urandom_range(0, 5));
      big      = ($urandom_range(0, 1) != 0) ? '1 : $urandom;
      product0 = $urandom;
      product1 = big;
      product2 = $urandom_range(0, 15);
      product3 = $urandom;
      tick();
      total_cnt++;
      if (act_vec() !== exp_vec())
        $display("FAIL random_c%0d got %h exp %h", c, act_vec(), exp_vec());
      else pass_cnt++;
    end
    idle_in();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) e_tot[i] = 0;
    e_cfg = SINGLE; e_len = 1; e_cnt = 0; e_busy = 0; e_ov = 0;
    idle_in();
    cfg = SINGLE; acc_len = 0;
    rst = 1;
    tick();
    test_reset();
    test_basic();
    test_gaps_stall();
    test_wrap();
    test_boundary();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
